// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained chunks, one chunk per clock,
// with valid/ready handshake and global stall.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : gs
    // Unconsumed operand bits shrink by CW per stage; finished result bits grow by CW.
    localparam int RW = WIDTH - k * CW;
    localparam int LW = (k + 1) * CW;
    logic [RW-1:0] ia, ib;
    logic [LW-1:0] ns, rs;
    logic [CW:0] t;
    logic ic, iv, rc, rv;
    assign t = {1'b0, ia[CW-1:0]} + {1'b0, ib[CW-1:0]} + {{CW{1'b0}}, ic};
    if (k == 0) begin : g_first
      assign ia = a;
      assign ib = b ^ {WIDTH{sub}};
      assign ic = cin ^ sub;
      assign iv = in_valid;
      assign ns = t[CW-1:0];
    end else begin : g_next
      assign ia = gs[k-1].g_op.ra;
      assign ib = gs[k-1].g_op.rb;
      assign ic = gs[k-1].rc;
      assign iv = gs[k-1].rv;
      assign ns = {t[CW-1:0], gs[k-1].rs};
    end
    if (k < STAGES - 1) begin : g_op
      logic [RW-CW-1:0] ra, rb;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          ra <= '0;
          rb <= '0;
        end else if (adv && iv) begin
          ra <= ia[RW-1:CW];
          rb <= ib[RW-1:CW];
        end
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rv <= 1'b0;
        rc <= 1'b0;
        rs <= '0;
      end else if (adv) begin
        rv <= iv;
        if (iv) begin
          rc <= t[CW];
          rs <= ns;
        end
      end
  end
  assign out_valid = gs[STAGES-1].rv;
  assign sum = gs[STAGES-1].rs;
  assign cout = gs[STAGES-1].rc;
  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (adv && gs[STAGES-1].iv) begin
      overflow <= gs[STAGES-1].t[CW] ^ gs[STAGES-1].t[CW-1] ^ gs[STAGES-1].ia[CW-1] ^ gs[STAGES-1].ib[CW-1];
      zero <= ~|gs[STAGES-1].ns;
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and streaming checks of pipelined_addsub over four (WIDTH,STAGES) configurations.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : (g == 2) ? 16 : 64;
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
    logic rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, zero, done;
    logic [W-1:0] a, b, sum;

    pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[W-1:0];
    endfunction

    // Returns {zero, overflow, cout, sum} from plain add / borrow-subtract arithmetic.
    function automatic logic [W+2:0] mdl(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
      logic [W:0] f;
      logic o, co;
      if (s) begin
        f = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        co = ~f[W];
        o = (x[W-1] != y[W-1]) && (f[W-1] != x[W-1]);
      end else begin
        f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        co = f[W];
        o = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
      end
      return {f[W-1:0] == '0, o, co, f[W-1:0]};
    endfunction

    task automatic single(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
      int lat;
      @(negedge clk);
      a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      #1 check($sformatf("w%0d_%s_rdy", W, tag), 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = rnd(); b = rnd(); cin = ~c; sub = ~s;
      lat = 1;
      while (!out_valid && lat < S + 8) begin
        @(posedge clk);
        #1 lat++;
      end
      check($sformatf("w%0d_%s_lat", W, tag), 128'(lat), 128'(S));
      check($sformatf("w%0d_%s_sum", W, tag), 128'(sum), 128'(es));
      check($sformatf("w%0d_%s_flags", W, tag), 128'({cout, overflow, zero}), 128'({ec, eo, ez}));
      @(posedge clk);
      #1 check($sformatf("w%0d_%s_once", W, tag), 128'(out_valid), 128'(0));
    endtask

    initial begin
      logic [W+2:0] q[$];
      logic [W+2:0] held;
      logic stl;
      int sent, got, cyc, ghost;
      done = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("w%0d_rst_outs", W), 128'({out_valid, sum, cout, overflow, zero}), 128'(0));
      check($sformatf("w%0d_rst_rdy", W), 128'(in_ready), 128'(1));
      @(negedge clk) rst = 1'b0;
      single("add", W'(1), W'(1), 1'b0, 1'b0, W'(2), 1'b0, 1'b0, 1'b0);
      single("carry", '1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      single("ovf", MAXP, W'(1), 1'b0, 1'b0, MINN, 1'b0, 1'b1, 1'b0);
      single("sub_bor", W'(5), W'(7), 1'b0, 1'b1, ~W'(1), 1'b0, 1'b0, 1'b0);
      single("sub_ovf", MINN, W'(1), 1'b0, 1'b1, MAXP, 1'b1, 1'b1, 1'b0);
      single("sub_bin", W'(9), W'(4), 1'b1, 1'b1, W'(4), 1'b1, 1'b0, 1'b0);
      sent = 0; got = 0; cyc = 0; stl = 1'b0; held = '0;
      while (got < 20 && cyc < 500) begin
        @(negedge clk);
        cyc++;
        out_ready = ($urandom_range(0, 2) != 0);
        in_valid = (sent < 20);
        a = rnd(); b = rnd(); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("w%0d_str_rdy", W), 128'(in_ready), 128'(!(out_valid && !out_ready)));
        if (stl) check($sformatf("w%0d_str_hold", W), 128'({zero, overflow, cout, sum}), 128'(held));
        if (out_valid && out_ready) begin
          if (q.size() == 0) check($sformatf("w%0d_str_extra", W), 128'(1), 128'(0));
          else check($sformatf("w%0d_str_res%0d", W, got), 128'({zero, overflow, cout, sum}), 128'(q.pop_front()));
          got++;
        end
        if (in_valid && in_ready) begin
          q.push_back(mdl(a, b, cin, sub));
          sent++;
        end
        stl = out_valid && !out_ready;
        held = {zero, overflow, cout, sum};
      end
      check($sformatf("w%0d_str_count", W), 128'(got), 128'(20));
      repeat (3) begin
        @(negedge clk);
        in_valid = 1'b1; a = W'(3); b = W'(4); cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
      end
      @(negedge clk) in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check($sformatf("w%0d_mid_rst", W), 128'({out_valid, sum}), 128'(0));
      check($sformatf("w%0d_mid_rdy", W), 128'(in_ready), 128'(1));
      @(negedge clk) rst = 1'b0;
      ghost = 0;
      repeat (S + 4) begin
        @(negedge clk) out_ready = 1'b1;
        #1 if (out_valid) ghost++;
      end
      check($sformatf("w%0d_ghost", W), 128'(ghost), 128'(0));
      single("post_rst", W'(1), W'(1), 1'b0, 1'b0, W'(2), 1'b0, 1'b0, 1'b0);
      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) break;
    end
    check("all_done", 128'({cfg[0].done, cfg[1].done, cfg[2].done, cfg[3].done}), 128'(4'hf));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined integer adder/subtractor, the successor to the team's fixed 32-bit ripple-carry adder. It splits a WIDTH-bit operation into STAGES carry-chained chunks, one chunk per clock, with a valid/ready stream handshake and back-pressure. It adds subtract mode, a borrow-aware carry, and signed-overflow and zero flags. It sits in the datapath wherever a full-width combinational carry chain would miss timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth and chunk count (1..WIDTH); chunk width CW = WIDTH/STAGES.
- clk  in  1  clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (sub: 1 = no borrow).
- overflow  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- Add: sum = a + b + cin, modulo 2^WIDTH; cout = bit WIDTH of the full sum.
- Sub: sum = a - b - cin, implemented as a + ~b + (~cin); cout = carry-out of that addition, so cout = 0 means a borrow occurred.
- overflow = (carry into bit WIDTH-1) XOR cout.
- zero = (sum == 0), computed on the final result.
- Pipeline stage k (0..STAGES-1) computes result bits [k*CW +: CW] from:
  - the operand chunks carried forward from acceptance (B is already inverted for sub);
  - the carry registered by stage k-1 (stage 0 uses the effective carry-in).
- Lower result chunks already computed, and upper operand chunks not yet consumed, travel forward in the stage registers alongside a per-stage valid bit.
- The last stage registers sum, cout, overflow, zero and out_valid.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. All stages shift together when adv = 1 and hold when adv = 0.
- A beat is accepted when in_valid && in_ready. A beat leaves when out_valid && out_ready.
- Bubbles (in_valid = 0 while adv = 1) propagate as invalid stages. Bubbles are never squeezed out while stalled.
- No internal FIFO: capacity is exactly STAGES beats in flight.
- Operands are sampled only on acceptance. Changes to a, b, cin or sub while in_ready = 0 have no effect.

## Timing
- Reset: out_valid, sum, cout, overflow, zero and all stage valid bits and data registers go to 0 asynchronously. in_ready reads 1 while reset is asserted and afterwards.
- Reset mid-operation discards all in-flight beats. out_valid drops in the same cycle reset asserts. No result from before reset ever emerges.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1 (visible STAGES cycles after the input cycle), with no stalls.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall: while out_valid && !out_ready, all outputs hold stable and in_ready = 0, in the same cycle, combinationally from out_ready.
- Simultaneous accept and emit in one cycle is legal and the normal streaming case.
- STAGES = 1: the block is one registered full-width adder with latency 1 and the same handshake.
- Flags are only meaningful when out_valid = 1. They hold their last value otherwise, or 0 after reset.

## Test plan
- Basic add, WIDTH=32, STAGES=4: a=1, b=1, cin=0, sub=0 -> sum=0x00000002, cout=0, overflow=0, zero=0, out_valid 4 cycles after the input cycle.
- Carry across all chunks: a=0xFFFFFFFF, b=0x00000001 -> sum=0, cout=1, zero=1, overflow=0. Then a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, cout=0.
- Subtract and borrow:
  - a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, overflow=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1, cout=1.
  - a=9, b=4, sub=1, cin=1 -> sum=4, cout=1.
- Streaming with back-pressure: 20 back-to-back random beats with out_ready toggled pseudo-randomly.
  - Results match the reference model in order, with no loss or duplication.
  - Outputs are stable while stalled.
  - in_ready == !(out_valid && !out_ready) every cycle.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle -> out_valid=0 and sum=0 immediately; none of the 3 results ever appear; the next beat has normal latency.
- Parameter sweep: repeat the basic add, carry-across-chunks and streaming scenarios with (WIDTH,STAGES) = (8,1), (16,2), (64,8) -> latency equals STAGES and results equal the model.
